event_unit_irq_dispatcher: RTL and testbench



---
 rtl/event_unit_irq_dispatcher.sv | 137 +++++++++++++
 tb/tb_event_unit_irq_dispatcher.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/event_unit_irq_dispatcher.sv
// Event unit interrupt buffer: captures event pulses, dispatches the lowest pending unmasked line to one core.
// Optional macro EU_IRQ_OVERFLOW_EN adds sticky per-line overflow flags (overflow_o / overflow_clr_i).
module event_unit_irq_dispatcher #(
    parameter int NUM_IRQ = 64,
    parameter int ID_W    = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_IRQ-1:0] event_i,
    input  logic [NUM_IRQ-1:0] mask_i,
    input  logic [NUM_IRQ-1:0] sw_clear_i,
    output logic               irq_req_o,
    output logic [ID_W-1:0]    irq_id_o,
    input  logic               irq_ack_i,
    input  logic [ID_W-1:0]    irq_ack_id_i,
    output logic [NUM_IRQ-1:0] buffer_status_o
`ifdef EU_IRQ_OVERFLOW_EN
    ,
    output logic [NUM_IRQ-1:0] overflow_o,
    input  logic [NUM_IRQ-1:0] overflow_clr_i
`endif
);

    // state | meaning
    // IDLE  | no request outstanding, dispatch lowest pending & unmasked line
    // REQ   | irq_req_o high, irq_id_o latched until ack or withdraw
    // GAP   | one cycle with irq_req_o low after an accepted ack
    typedef enum logic [1:0] {IDLE, REQ, GAP} state_t;

    localparam logic [ID_W-1:0] ID_NONE = '1;

    state_t             state_q, state_d;
    logic [NUM_IRQ-1:0] pending_q, pending_d;
    logic [NUM_IRQ-1:0] cand, ack_clr, clr;
    logic [ID_W-1:0]    sel_id, id_d;
    logic               req_d, any_cand, ack_ok;
    logic               lat_pend_nxt, lat_mask;

    assign cand     = pending_q & mask_i;
    assign any_cand = |cand;

    always_comb begin
        sel_id = ID_NONE;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (cand[i]) sel_id = ID_W'(i);
        end
    end

    assign ack_ok = (state_q == REQ) && irq_ack_i && (irq_ack_id_i == irq_id_o)
                    && (int'(irq_ack_id_i) < NUM_IRQ);

    // Per-line view of the latched request; withdraw ignores the ack path, so no loop through pending_d.
    always_comb begin
        ack_clr      = '0;
        lat_pend_nxt = 1'b0;
        lat_mask     = 1'b0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (ID_W'(i) == irq_id_o) begin
                ack_clr[i]   = ack_ok;
                lat_pend_nxt = (pending_q[i] & ~sw_clear_i[i]) | event_i[i];
                lat_mask     = mask_i[i];
            end
        end
    end

    assign clr       = sw_clear_i | ack_clr;
    assign pending_d = (pending_q & ~clr) | event_i;

    always_comb begin
        state_d = state_q;
        req_d   = irq_req_o;
        id_d    = irq_id_o;
        case (state_q)
            IDLE: begin
                if (any_cand) begin
                    state_d = REQ;
                    req_d   = 1'b1;
                    id_d    = sel_id;
                end
            end
            REQ: begin
                if (ack_ok) begin
                    state_d = GAP;
                    req_d   = 1'b0;
                    id_d    = ID_NONE;
                end else if (!lat_pend_nxt || !lat_mask) begin
                    state_d = IDLE;
                    req_d   = 1'b0;
                    id_d    = ID_NONE;
                end
            end
            GAP: begin
                state_d = IDLE;
                req_d   = 1'b0;
                id_d    = ID_NONE;
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
                id_d    = ID_NONE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            irq_req_o <= 1'b0;
            irq_id_o  <= ID_NONE;
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            irq_req_o <= req_d;
            irq_id_o  <= id_d;
            pending_q <= pending_d;
        end
    end

    assign buffer_status_o = pending_q;

`ifdef EU_IRQ_OVERFLOW_EN
    logic [NUM_IRQ-1:0] overflow_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q <= '0;
        end else begin
            overflow_q <= (overflow_q & ~overflow_clr_i) | (event_i & pending_q & ~clr);
        end
    end

    assign overflow_o = overflow_q;
`else
    // Duplicate events merge silently into the pending bit.
`endif

endmodule

// File: tb/tb_event_unit_irq_dispatcher.sv
// Scoreboard bench for event_unit_irq_dispatcher: directed plan items plus random traffic vs. a behavioural model.
module tb_event_unit_irq_dispatcher;
    localparam int N = 64;
    localparam int W = 8;
    localparam logic [W-1:0] NONE = 8'hFF;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] event_i = '0, mask_i = '0, sw_clear_i = '0;
    logic         irq_req_o;
    logic [W-1:0] irq_id_o;
    logic         irq_ack_i = 1'b0;
    logic [W-1:0] irq_ack_id_i = '0;
    logic [N-1:0] buffer_status_o;
    logic [N-1:0] ov_clr = '0;
`ifdef EU_IRQ_OVERFLOW_EN
    logic [N-1:0] overflow_o;
    logic [N-1:0] overflow_clr_i;
    assign overflow_clr_i = ov_clr;
`endif

    event_unit_irq_dispatcher #(.NUM_IRQ(N), .ID_W(W)) dut (
        .clk(clk), .rst_n(rst_n), .event_i(event_i), .mask_i(mask_i), .sw_clear_i(sw_clear_i),
        .irq_req_o(irq_req_o), .irq_id_o(irq_id_o), .irq_ack_i(irq_ack_i),
        .irq_ack_id_i(irq_ack_id_i), .buffer_status_o(buffer_status_o)
`ifdef EU_IRQ_OVERFLOW_EN
        , .overflow_o(overflow_o), .overflow_clr_i(overflow_clr_i)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int           tag;
        logic         req;
        logic [W-1:0] id;
        logic [N-1:0] st;
        logic [N-1:0] ov;
    } exp_t;

    exp_t q[$];
    int errors = 0;
    int checks = 0;

    // Behavioural model: pending set, the line currently offered (-1 = none), edges still blocked after an ack.
    logic [N-1:0] m_pend = '0, m_ovf = '0;
    int m_cur = -1;
    int m_quiet = 0;

    function automatic logic [N-1:0] bit_of(input int i);
        logic [N-1:0] b;
        b = '0;
        b[i] = 1'b1;
        return b;
    endfunction

    task automatic model_reset();
        m_pend = '0; m_ovf = '0; m_cur = -1; m_quiet = 0;
    endtask

    task automatic step(input logic [N-1:0] ev, input logic [N-1:0] msk, input logic [N-1:0] swc,
                        input logic ack, input logic [W-1:0] ackid);
        logic acc;
        logic [N-1:0] clr, newp;
        exp_t e;
        @(negedge clk);
        event_i = ev; mask_i = msk; sw_clear_i = swc; irq_ack_i = ack; irq_ack_id_i = ackid;
        acc = (m_cur >= 0) && ack && (int'(ackid) == m_cur);
        clr = swc;
        if (acc) clr[m_cur] = 1'b1;
        newp = (m_pend & ~clr) | ev;
        m_ovf = (m_ovf & ~ov_clr) | (ev & m_pend & ~clr);
        if (m_cur >= 0) begin
            if (acc) begin
                m_cur = -1;
                m_quiet = 1;
            end else if (!msk[m_cur] || !newp[m_cur]) begin
                m_cur = -1;
            end
        end else if (m_quiet > 0) begin
            m_quiet--;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (m_pend[i] && msk[i]) begin
                    m_cur = i;
                    break;
                end
            end
        end
        m_pend = newp;
        e.tag = cyc + 1;
        e.req = (m_cur >= 0);
        e.id  = (m_cur >= 0) ? W'(m_cur) : NONE;
        e.st  = m_pend;
        e.ov  = m_ovf;
        q.push_back(e);
    endtask

    task automatic idle();
        step('0, '1, '0, 1'b0, '0);
    endtask

    task automatic ev1(input int i);
        step(bit_of(i), '1, '0, 1'b0, '0);
    endtask

    task automatic ack1(input int i);
        step('0, '1, '0, 1'b1, W'(i));
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        while (q.size() > 0 && q[0].tag <= cyc) begin
            e = q.pop_front();
            checks++;
            if (irq_req_o !== e.req || irq_id_o !== e.id || buffer_status_o !== e.st
`ifdef EU_IRQ_OVERFLOW_EN
                || overflow_o !== e.ov
`endif
            ) begin
                errors++;
                $display("FAIL scoreboard cyc=%0d: req=%b id=%0h st=%0h, expected req=%b id=%0h st=%0h",
                         cyc, irq_req_o, irq_id_o, buffer_status_o, e.req, e.id, e.st);
            end
        end
    end

    initial begin
        logic [N-1:0] ev, msk, swc;
        logic ack;
        logic [W-1:0] aid;

        repeat (2) @(negedge clk);
        chk("reset_req", 64'(irq_req_o), 64'd0);
        chk("reset_id", 64'(irq_id_o), 64'(NONE));
        chk("reset_status", buffer_status_o, 64'd0);
        rst_n = 1'b1;

        // single event 5
        ev1(5); idle();
        chk("ev5_status", 64'(buffer_status_o[5]), 64'd1);
        chk("ev5_req_not_yet", 64'(irq_req_o), 64'd0);
        idle();
        chk("ev5_req", 64'(irq_req_o), 64'd1);
        chk("ev5_id", 64'(irq_id_o), 64'd5);
        ack1(5); idle();
        chk("ev5_ack_req", 64'(irq_req_o), 64'd0);
        chk("ev5_ack_id", 64'(irq_id_o), 64'(NONE));
        chk("ev5_ack_status", 64'(buffer_status_o[5]), 64'd0);

        // events 9 and 3 together, then event 2 arrives while 9 is offered
        step(bit_of(9) | bit_of(3), '1, '0, 1'b0, '0); idle(); idle();
        chk("prio_first", 64'(irq_id_o), 64'd3);
        ack1(3); idle();
        chk("gap_low", 64'(irq_req_o), 64'd0);
        idle();
        chk("idle_low", 64'(irq_req_o), 64'd0);
        idle();
        chk("second_req", 64'(irq_req_o), 64'd1);
        chk("second_id", 64'(irq_id_o), 64'd9);
        ev1(2); idle(); idle();
        chk("no_preempt", 64'(irq_id_o), 64'd9);
        ack1(9); idle(); idle(); idle();
        chk("after_9", 64'(irq_id_o), 64'd2);
        ack1(2); idle(); idle();

        // wrong-id ack, then software clear withdraws
        ev1(4); idle(); idle();
        chk("id4", 64'(irq_id_o), 64'd4);
        ack1(6); idle();
        chk("wrong_ack_held", 64'(irq_req_o), 64'd1);
        step('0, '1, bit_of(4), 1'b0, '0); idle();
        chk("withdraw_req", 64'(irq_req_o), 64'd0);
        chk("withdraw_id", 64'(irq_id_o), 64'(NONE));
        chk("withdraw_pend", 64'(buffer_status_o[4]), 64'd0);

        // event coinciding with its own ack is re-requested after the gap
        ev1(7); idle(); idle();
        step(bit_of(7), '1, '0, 1'b1, 8'd7); idle();
        chk("set_wins_pend", 64'(buffer_status_o[7]), 64'd1);
        chk("set_wins_req", 64'(irq_req_o), 64'd0);
        idle(); idle();
        chk("rereq_id", 64'(irq_id_o), 64'd7);
        ev1(7); ev1(7); idle();
`ifdef EU_IRQ_OVERFLOW_EN
        chk("overflow_set", 64'(overflow_o[7]), 64'd1);
        ov_clr = bit_of(7);
        idle();
        ov_clr = '0;
        idle();
        chk("overflow_clr", 64'(overflow_o[7]), 64'd0);
`endif
        step('0, '1, '0, 1'b1, 8'hFF); idle();
        chk("ack_ff_ignored", 64'(irq_req_o), 64'd1);
        ack1(7); idle(); idle();

        // random traffic
        for (int t = 0; t < 600; t++) begin
            ev = '0;
            for (int i = 0; i < N; i++) if ($urandom_range(0, 63) == 0) ev[i] = 1'b1;
            msk = '1;
            if ($urandom_range(0, 7) == 0) msk = {$urandom, $urandom};
            swc = '0;
            if ($urandom_range(0, 9) == 0) swc[$urandom_range(0, N - 1)] = 1'b1;
            ov_clr = '0;
            if ($urandom_range(0, 15) == 0) ov_clr = {$urandom, $urandom};
            ack = 1'b0;
            aid = '0;
            if ($urandom_range(0, 2) == 0) begin
                ack = 1'b1;
                if (m_cur >= 0 && $urandom_range(0, 3) != 0) aid = W'(m_cur);
                else aid = W'($urandom_range(0, 255));
            end
            step(ev, msk, swc, ack, aid);
        end
        ov_clr = '0;
        idle(); idle(); idle();

        // asynchronous reset while a request is outstanding
        ev1(10); idle(); idle();
        for (int k = 0; k < 8 && !irq_req_o; k++) idle();
        if (!irq_req_o) begin
            checks++;
            errors++;
            $display("FAIL req_timeout: got req=0 expected req=1 within bound");
        end
        #2;
        rst_n = 1'b0;
        q.delete();
        model_reset();
        event_i = '0; sw_clear_i = '0; irq_ack_i = 1'b0; irq_ack_id_i = '0;
        #1;
        chk("async_rst_req", 64'(irq_req_o), 64'd0);
        chk("async_rst_id", 64'(irq_id_o), 64'(NONE));
        chk("async_rst_status", buffer_status_o, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ev1(1); idle(); idle();
        chk("post_rst_id", 64'(irq_id_o), 64'd1);
        ack1(1); idle(); idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
